// File: rtl/sample_deserializer_if.sv
// Handshake/serial bundle between the sample deserializer and its neighbours:
// serial input side, and parallel output with valid/ready and status flags.
interface sample_deserializer_if #(
  parameter int WIDTH     = 12,
  parameter int OVR_CNT_W = 8
);
  logic                 sdata;
  logic                 sframe;
  logic [WIDTH-1:0]     d;
  logic                 d_valid;
  logic                 d_ready;
  logic                 frame_err;
  logic                 overrun;
  logic [OVR_CNT_W-1:0] ovr_count;

  modport master (
    input  sdata, sframe, d_ready,
    output d, d_valid, frame_err, overrun, ovr_count
  );

  modport slave (
    output sdata, sframe, d_ready,
    input  d, d_valid, frame_err, overrun, ovr_count
  );
endinterface

// File: rtl/sample_deserializer.sv
// Serial-to-parallel sample assembler feeding the float converter: MSB-first
// framed words, double-buffered output register with valid/ready and overrun stats.
module sample_deserializer #(
  parameter int WIDTH     = 12,
  parameter int OVR_CNT_W = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  sample_deserializer_if.master  bus
);

  localparam int                   CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]     LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [OVR_CNT_W-1:0] OVR_MAX  = {OVR_CNT_W{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     sh_q, sh_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     d_q, d_d;
  logic                 d_valid_q, d_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic [OVR_CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;
  logic                 done_s;
  logic [WIDTH-1:0]     word_s;

  // The completed word includes the bit being sampled on this edge.
  assign word_s = {sh_q[WIDTH-2:0], bus.sdata};

  // State register and all output/status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sh_q        <= {WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      d_q         <= {WIDTH{1'b0}};
      d_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      ovr_cnt_q   <= {OVR_CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      d_q         <= d_d;
      d_valid_q   <= d_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      ovr_cnt_q   <= ovr_cnt_d;
    end
  end

  // Framing FSM: an sframe always starts a new word, aborting one in progress.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;
    done_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.sframe) begin
          sh_d    = {{(WIDTH-1){1'b0}}, bus.sdata};
          cnt_d   = CNT_ONE;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (bus.sframe) begin
          frame_err_d = 1'b1;
          sh_d        = {{(WIDTH-1){1'b0}}, bus.sdata};
          cnt_d       = CNT_ONE;
          state_d     = SHIFT;
        end else if (cnt_q == LAST_IDX) begin
          sh_d    = word_s;
          cnt_d   = {CNT_W{1'b0}};
          done_s  = 1'b1;
          state_d = IDLE;
        end else begin
          sh_d    = word_s;
          cnt_d   = cnt_q + CNT_ONE;
          state_d = SHIFT;
        end
      end
      default: begin
        sh_d    = {WIDTH{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
        state_d = IDLE;
      end
    endcase
  end

  // Output buffer: a full, unconsumed buffer drops the new word and counts it.
  always_comb begin
    d_d       = d_q;
    d_valid_d = d_valid_q;
    overrun_d = overrun_q;
    ovr_cnt_d = ovr_cnt_q;
    if (done_s) begin
      if (!d_valid_q || bus.d_ready) begin
        d_d       = word_s;
        d_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
        if (ovr_cnt_q != OVR_MAX) begin
          ovr_cnt_d = ovr_cnt_q + {{(OVR_CNT_W-1){1'b0}}, 1'b1};
        end else begin
          ovr_cnt_d = ovr_cnt_q;
        end
      end
    end else if (d_valid_q && bus.d_ready) begin
      d_valid_d = 1'b0;
    end else begin
      d_valid_d = d_valid_q;
    end
  end

  assign bus.d         = d_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.ovr_count = ovr_cnt_q;

endmodule

// File: tb/tb_sample_deserializer.sv
// Directed bench for sample_deserializer: inputs change and outputs are
// sampled on the falling clock edge; expected values are hand-computed.
module tb_sample_deserializer;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  int   ferr_seen;

  sample_deserializer_if #(.WIDTH(12), .OVR_CNT_W(8)) bus_if ();

  sample_deserializer #(.WIDTH(12), .OVR_CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one MSB-first word; returns at the falling edge that presents bit 0.
  task automatic send_word(input logic [11:0] w);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus_if.frame_err === 1'b1) ferr_seen++;
      bus_if.sframe = (i == 0);
      bus_if.sdata  = w[11-i];
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus_if.sframe = 1'b0;
    bus_if.sdata  = 1'b0;
  endtask

  initial begin
    logic [23:0] pair;
    logic [11:0] part;
    tests_run     = 0;
    tests_failed  = 0;
    ferr_seen     = 0;
    rst_n         = 1'b0;
    bus_if.sdata  = 1'b0;
    bus_if.sframe = 1'b0;
    bus_if.d_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_d",         32'(bus_if.d),         32'h0);
    check_eq("rst_d_valid",   32'(bus_if.d_valid),   32'h0);
    check_eq("rst_frame_err", 32'(bus_if.frame_err), 32'h0);
    check_eq("rst_overrun",   32'(bus_if.overrun),   32'h0);
    check_eq("rst_ovr_count", 32'(bus_if.ovr_count), 32'h0);
    rst_n = 1'b1;
    idle_cycle();

    // Words 44..48 with the consumer always ready.
    for (int v = 44; v <= 48; v++) begin
      send_word(12'(v));
      check_eq("seq_pre_valid", 32'(bus_if.d_valid), 32'h0);
      idle_cycle();
      check_eq("seq_d",       32'(bus_if.d),       32'(v));
      check_eq("seq_d_valid", 32'(bus_if.d_valid), 32'h1);
      idle_cycle();
      check_eq("seq_consumed", 32'(bus_if.d_valid), 32'h0);
    end

    // Back-to-back 0xFFF then 0x800.
    pair = {12'hFFF, 12'h800};
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 12) check_eq("b2b_first",  32'(bus_if.d), 32'hFFF);
      if (i == 23) check_eq("b2b_hold",   32'(bus_if.d), 32'hFFF);
      if (bus_if.frame_err === 1'b1) ferr_seen++;
      bus_if.sframe = ((i % 12) == 0);
      bus_if.sdata  = pair[23-i];
    end
    idle_cycle();
    check_eq("b2b_second",    32'(bus_if.d),         32'h800);
    check_eq("b2b_valid",     32'(bus_if.d_valid),   32'h1);
    check_eq("b2b_ferr_cnt",  32'(ferr_seen),        32'h0);
    check_eq("b2b_overrun",   32'(bus_if.overrun),   32'h0);
    idle_cycle();

    // Consume on the exact completion edge of 0x7FF.
    bus_if.d_ready = 1'b0;
    send_word(12'h555);
    idle_cycle();
    check_eq("cc_hold_d", 32'(bus_if.d), 32'h555);
    send_word(12'h7FF);
    bus_if.d_ready = 1'b1;
    idle_cycle();
    check_eq("cc_d",       32'(bus_if.d),       32'h7FF);
    check_eq("cc_valid",   32'(bus_if.d_valid), 32'h1);
    check_eq("cc_overrun", 32'(bus_if.overrun), 32'h0);
    idle_cycle();
    check_eq("cc_consumed", 32'(bus_if.d_valid), 32'h0);

    // Abort after 5 bits, then a full 0xABC.
    ferr_seen = 0;
    part = 12'hFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus_if.sframe = (i == 0);
      bus_if.sdata  = part[11-i];
    end
    send_word(12'hABC);
    check_eq("abort_no_early_valid", 32'(bus_if.d_valid), 32'h0);
    idle_cycle();
    check_eq("abort_ferr_pulses", 32'(ferr_seen),        32'h1);
    check_eq("abort_ferr_low",    32'(bus_if.frame_err), 32'h0);
    check_eq("abort_d",           32'(bus_if.d),         32'hABC);
    check_eq("abort_valid",       32'(bus_if.d_valid),   32'h1);
    idle_cycle();

    // Overrun: consumer stalled, second word dropped.
    bus_if.d_ready = 1'b0;
    send_word(12'h123);
    send_word(12'h456);
    idle_cycle();
    check_eq("ovr_d",     32'(bus_if.d),         32'h123);
    check_eq("ovr_valid", 32'(bus_if.d_valid),   32'h1);
    check_eq("ovr_flag",  32'(bus_if.overrun),   32'h1);
    check_eq("ovr_count", 32'(bus_if.ovr_count), 32'h1);
    bus_if.d_ready = 1'b1;
    @(negedge clk);
    bus_if.d_ready = 1'b0;
    check_eq("ovr_consumed", 32'(bus_if.d_valid), 32'h0);
    check_eq("ovr_d_kept",   32'(bus_if.d),       32'h123);
    check_eq("ovr_sticky",   32'(bus_if.overrun), 32'h1);

    // Reset mid-word while a sample is held.
    send_word(12'h3C3);
    part = 12'hFFF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus_if.sframe = (i == 0);
      bus_if.sdata  = part[11-i];
    end
    @(negedge clk);
    rst_n = 1'b0;
    bus_if.sframe = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("mrst_d",       32'(bus_if.d),         32'h0);
    check_eq("mrst_valid",   32'(bus_if.d_valid),   32'h0);
    check_eq("mrst_overrun", 32'(bus_if.overrun),   32'h0);
    check_eq("mrst_count",   32'(bus_if.ovr_count), 32'h0);
    bus_if.d_ready = 1'b1;
    idle_cycle();
    check_eq("mrst_no_partial", 32'(bus_if.d_valid), 32'h0);
    send_word(12'h001);
    idle_cycle();
    check_eq("mrst_next_d",     32'(bus_if.d),       32'h001);
    check_eq("mrst_next_valid", 32'(bus_if.d_valid), 32'h1);

    // Saturation: hold one word, drop 254 then 3 more.
    bus_if.d_ready = 1'b0;
    for (int k = 0; k < 254; k++) send_word(12'(k));
    idle_cycle();
    check_eq("sat_fe", 32'(bus_if.ovr_count), 32'hFE);
    for (int k = 0; k < 3; k++) send_word(12'(k));
    idle_cycle();
    check_eq("sat_ff",   32'(bus_if.ovr_count), 32'hFF);
    check_eq("sat_d",    32'(bus_if.d),         32'h001);
    check_eq("sat_flag", 32'(bus_if.overrun),   32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sample_deserializer.md
Name: sample_deserializer

Overview:
- Upstream feeder for the floating-point converter.
- Receives 12-bit two's-complement samples MSB-first on a 1-bit serial line, framed by a start strobe.
- Assembles each sample and holds it in an output register with a valid/ready handshake.
- Output `d` connects directly to the converter's `d` input; `d_valid`/`d_ready` pace the downstream capture logic.
- Double-buffered: the next sample can shift in while the previous one waits to be consumed.

Parameters:
- WIDTH, 12: sample width in bits; equals the converter input width.
- OVR_CNT_W, 8: width of the saturating overrun counter.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- sdata  input  1  serial data bit, sampled every clk edge while a word is in progress.
- sframe  input  1  start-of-word strobe; high in the same cycle as the MSB.
- d  output  WIDTH  assembled two's-complement sample (to converter `d`).
- d_valid  output  1  `d` holds an unconsumed sample.
- d_ready  input  1  consumer accepts `d` on an edge where d_valid && d_ready.
- frame_err  output  1  one-cycle pulse: word aborted by an early sframe.
- overrun  output  1  sticky: a completed word was dropped because the output was full.
- ovr_count  output  OVR_CNT_W  number of dropped words, saturating at all-ones.

Behaviour:
- Reset (rst_n low at an edge)
  - Outputs: d=0, d_valid=0, frame_err=0, overrun=0, ovr_count=0.
  - Internal: FSM=IDLE, shift register=0, bit counter=0.
  - Reset mid-word or mid-hold discards everything; no partial word is ever presented.
- FSM states: IDLE, SHIFT.
  - IDLE: sdata ignored unless sframe=1. When sframe=1, shift in sdata as the MSB, set cnt=1, go to SHIFT.
  - SHIFT, sframe=0: shift sdata in LSB-ward: sh <= {sh[WIDTH-2:0], sdata}; cnt++.
  - SHIFT, sframe=0, edge sampling bit index WIDTH-1 (the last bit): word complete, go to IDLE.
  - SHIFT, sframe=1 (any cnt, including the last-bit slot): abort the current word and pulse frame_err for one cycle. The bit sampled this cycle becomes the MSB of a new word; cnt=1; stay in SHIFT.
- Timing and throughput:
  - Word complete at edge N (the edge sampling the last bit) → d/d_valid visible from edge N+1. Latency is 1 cycle after the last bit.
  - Back-to-back frames: sframe may be asserted in the first cycle after the last bit; this gives full throughput of 1 word per WIDTH cycles.
- Output register / handshake:
  - Load on completion: if d_valid=0, or d_valid=1 and d_ready=1 on the same edge → d <= completed word, d_valid <= 1.
  - If d_valid=1 and d_ready=0 at completion: drop the new word, keep the old d, set overrun=1 (sticky until reset), and increment ovr_count unless it is already all-ones.
  - Consume with no completion on that edge: d_valid <= 0; d keeps its last value.
  - While d_valid=1 and d_ready=0, d and d_valid are stable.
  - d_ready while d_valid=0: no effect.
- Widths: d is raw bits, no sign handling; the shift register is exactly WIDTH bits; cnt covers 0..WIDTH-1.

Test Plan:
- Send 12'h02C (decimal 44) with sframe on the MSB cycle, d_ready=1 → d=12'h02C, d_valid high exactly 1 cycle after the 12th bit. Repeat for 45..48 → d = 12'h02D..12'h030.
- Send 12'hFFF, then 12'h800 back-to-back, d_ready=1 → d=12'hFFF, then d=12'h800 exactly 12 cycles later; frame_err and overrun stay 0.
- Hold d_ready=0; send 12'h123, then 12'h456 → d stays 12'h123, overrun=1, ovr_count=1. Then d_ready=1 for one cycle → d_valid=0.
- d_valid=1 with d_ready=1 on the exact completion edge of 12'h7FF → d=12'h7FF, d_valid stays 1, overrun=0.
- Assert sframe after 5 bits of a word, then send a full 12'hABC → frame_err pulses once (1 cycle); only d=12'hABC appears.
- Assert rst_n=0 for 1 cycle mid-word → all outputs 0. Next full frame 12'h001 → d=12'h001. Also: 256+ dropped words → ovr_count saturates at 8'hFF.
